add_seq: RTL and testbench
==========================

# add_seq

Multi-precision add sequencer that owns the shared 8-bit carry adder (`add8c`) and drives it one byte per cycle. It accepts NBYTES-wide operands over a valid/ready request channel and feeds byte lanes LSB-first with the carry chained through a register. It returns the full sum and carry-out over a valid/ready response channel. It sits between a Karuta-generated datapath and the single `add8c` instance, so wide additions cost no extra adder area.

## Interface
- NBYTES, 4, operand width in bytes (≥1); word width W = 8*NBYTES
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_a  in  W  operand A
- req_b  in  W  operand B
- req_cin  in  1  carry-in for add
- req_sub  in  1  subtract select; ignored unless ADD_SEQ_SUB_EN
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts result
- resp_sum  out  W  result word
- resp_cout  out  1  carry-out of MSB byte (subtract: 1 = no borrow)
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - latch A, B.
  - carry reg = req_cin (add), or 1 (subtract, B latched inverted).
  - idx=0; go to RUN.
- RUN: the adder sees arg_0=A[idx], arg_1=B[idx], arg_2=carry.
  - Each cycle: sum byte idx ← ret_1; carry ← ret_0; idx+1.
  - When idx==NBYTES-1 is processed, go to DONE.
- DONE: resp_valid=1 with resp_sum/resp_cout stable. On resp_ready go to IDLE.
- req_ready=0 in RUN and DONE. A request presented there is not accepted and must be held by the requester.
- Width: each byte add is 9-bit. Sum wraps modulo 2^W; only the final carry is exported. No intermediate carries are exposed.
- NBYTES=1: RUN lasts exactly one cycle.
- Reset values (rst=0, any state, including mid-RUN):
  - state=IDLE, req_ready=1, resp_valid=0, busy=0, resp_sum=0, resp_cout=0.
  - idx=0, carry=0.
  - An in-flight operation is discarded, with no partial response.

## Timing
- Accept at rising edge k → RUN during cycles k..k+NBYTES-1 → resp_valid high from edge k+NBYTES.
- Latency is NBYTES cycles from accept to resp_valid.
- Minimum period between accepts is NBYTES+2 cycles: one DONE cycle with resp_ready=1, then one IDLE cycle.
- resp_ready is sampled only in DONE. If it is already high when DONE is entered, DONE lasts one cycle.
- resp_sum and resp_cout do not change while resp_valid=1. They keep the last result after the handshake until the next RUN overwrites byte lanes.
- No combinational path from req_* to req_ready, or from resp_ready to resp_*.

## Configuration
- ADD_SEQ_SUB_EN defined:
  - req_sub=1 latches ~req_b and forces the initial carry to 1, computing A−B.
  - resp_cout=0 indicates a borrow.
- Undefined: req_sub is ignored; every operation is A+B+req_cin. The inversion mux is not synthesized.

## Structure
- Shared package add_seq_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - BYTE_W=8
  - function for idx width ($clog2(NBYTES), min 1)
- Sub-module: one `add8c` instance (clk/rst passed through; it is purely combinational). No other sub-modules. The byte-lane mux and demux are inline.

## Test plan
- NBYTES=4, A=0x000000FF, B=0x00000001, cin=0 → sum 0x00000100, cout 0, resp_valid exactly 4 cycles after accept.
- A=0xFFFFFFFF, B=0x00000000, cin=1 → sum 0x00000000, cout 1 (full carry ripple across 4 bytes).
- Hold resp_ready=0 for 3 cycles in DONE with req_valid=1 → resp_sum stable, req_ready=0, the new request is accepted only after the response handshake plus one IDLE cycle.
- Assert rst=0 after the 2nd RUN cycle → all outputs at reset values immediately. After release, A=0x12345678 + B=0x11111111 → 0x23456789, cout 0.
- With ADD_SEQ_SUB_EN, req_sub=1, A=0x00000005, B=0x00000007 → sum 0xFFFFFFFE, cout 0. Without the macro, the same stimulus with cin=0 → 0x0000000C, cout 0.
- NBYTES=1, A=0x80, B=0x80, cin=1 → sum 0x01, cout 1, resp_valid 1 cycle after accept.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
// Optional feature macro: ADD_SEQ_SUB_EN (enables subtract via inverted B and forced carry-in).
package add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte-index width; a one-byte word still needs a one-bit index register.
  function automatic int idx_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/add8c.sv
// Shared 8-bit adder with carry-in and carry-out; purely combinational.
// clk/rst are part of the shared instance's port list but drive no logic.
module add8c
  import add_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] arg_0,
  input  logic [BYTE_W-1:0] arg_1,
  input  logic              arg_2,
  output logic              ret_0,
  output logic [BYTE_W-1:0] ret_1
);

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign {ret_0, ret_1} = (BYTE_W + 1)'(arg_0) + (BYTE_W + 1)'(arg_1) + (BYTE_W + 1)'(arg_2);

endmodule

// File: rtl/add_seq.sv
// Multi-precision add sequencer: feeds one byte lane per cycle, LSB first, through add8c.
// Optional feature macro: ADD_SEQ_SUB_EN (req_sub selects A-B; otherwise req_sub is ignored).
module add_seq
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4,
  localparam int W     = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
  input  logic         req_sub,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_sum,
  output logic         resp_cout,
  output logic         busy
);

  localparam int                IDX_W    = idx_w(NBYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

  typedef logic [NBYTES-1:0][BYTE_W-1:0] word_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  word_t            a_q, a_d;
  word_t            b_q, b_d;
  word_t            sum_q, sum_d;

  logic [BYTE_W-1:0] add_sum;
  logic              add_cout;

  add8c u_add8c (
    .clk  (clk),
    .rst  (rst),
    .arg_0(a_q[idx_q]),
    .arg_1(b_q[idx_q]),
    .arg_2(carry_q),
    .ret_0(add_cout),
    .ret_1(add_sum)
  );

  logic [W-1:0] b_load;
  logic         carry_load;

`ifdef ADD_SEQ_SUB_EN
  assign b_load     = req_sub ? ~req_b : req_b;
  assign carry_load = req_sub ? 1'b1 : req_cin;
`else
  logic unused_req_sub;
  assign unused_req_sub = req_sub;
  assign b_load         = req_b;
  assign carry_load     = req_cin;
`endif

  // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = b_load;
          carry_d = carry_load;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_sum;
        carry_d      = add_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_sum   = sum_q;
  assign resp_cout  = cout_q;

endmodule

// File: tb/tb_add_seq.sv
// Directed self-checking bench for add_seq: a 4-byte instance plus a 1-byte instance.
module tb_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-byte instance
  logic        req_valid = 1'b0, req_cin = 1'b0, req_sub = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, resp_valid, resp_cout, busy;
  logic [31:0] resp_sum;

  add_seq #(.NBYTES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy)
  );

  // 1-byte instance
  logic       r1_valid = 1'b0, r1_cin = 1'b0, r1_sub = 1'b0, r1_rready = 1'b1;
  logic [7:0] r1_a = '0, r1_b = '0;
  logic       r1_ready, r1_rvalid, r1_cout, r1_busy;
  logic [7:0] r1_sum;

  add_seq #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(r1_valid), .req_ready(r1_ready),
    .req_a(r1_a), .req_b(r1_b), .req_cin(r1_cin), .req_sub(r1_sub),
    .resp_valid(r1_rvalid), .resp_ready(r1_rready),
    .resp_sum(r1_sum), .resp_cout(r1_cout), .busy(r1_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request once ready, hold it through the accepting edge, then drop it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL issue_ready_timeout: req_ready=%0b required 1", req_ready);
    end
    req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Count edges after the accept until resp_valid rises.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub,
                        input logic [31:0] exp_sum, input logic exp_cout);
    int lat;
    issue(a, b, cin, sub);
    wait_resp(lat);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid: resp_valid=%b required 1", name, resp_valid);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL %s_latency: %0d cycles required 4", name, lat);
    end
    checks++;
    if (resp_sum !== exp_sum) begin
      errors++; $display("FAIL %s_sum: %h required %h", name, resp_sum, exp_sum);
    end
    checks++;
    if (resp_cout !== exp_cout) begin
      errors++; $display("FAIL %s_cout: %b required %b", name, resp_cout, exp_cout);
    end
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({req_ready, resp_valid, busy, resp_cout} !== 4'b1000 || resp_sum !== 32'h0) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b busy=%b cout=%b sum=%h required ready=1 valid=0 busy=0 cout=0 sum=00000000",
               name, req_ready, resp_valid, busy, resp_cout, resp_sum);
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_outputs("reset_state");
    checks++;
    if ({r1_ready, r1_rvalid, r1_busy, r1_cout} !== 4'b1000 || r1_sum !== 8'h00) begin
      errors++; $display("FAIL reset_state_n1: ready=%b valid=%b busy=%b", r1_ready, r1_rvalid, r1_busy);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_add();
    run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
    run_op("ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    run_op("carry_in", 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] held;
    resp_ready = 1'b0;
    issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
    wait_resp(lat);
    held = resp_sum;
    checks++;
    if (held !== 32'h1010_1010) begin
      errors++; $display("FAIL bp_sum: %h required 10101010", held);
    end
    // New request waits while the response is stalled.
    req_a = 32'h0000_0001; req_b = 32'h0000_0002; req_cin = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (resp_sum !== 32'h1010_1010 || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: sum=%h valid=%b ready=%b required 10101010 1 0", i, resp_sum, resp_valid, req_ready);
      end
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || resp_sum !== 32'h1010_1010) begin
      errors++;
      $display("FAIL bp_idle: valid=%b ready=%b busy=%b sum=%h required 0 1 0 10101010", resp_valid, req_ready, busy, resp_sum);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL bp_accept: busy=%b required 1", busy);
    end
    wait_resp(lat);
    checks++;
    if (lat !== 4 || resp_sum !== 32'h0000_0004 || resp_cout !== 1'b0) begin
      errors++; $display("FAIL bp_second: lat=%0d sum=%h cout=%b required 4 00000004 0", lat, resp_sum, resp_cout);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_run");
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_op("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);
  endtask

  task automatic test_sub();
`ifdef ADD_SEQ_SUB_EN
    run_op("sub", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_no_borrow", 32'h0000_0009, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
`else
    run_op("sub_ignored", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0);
`endif
  endtask

  task automatic test_nbytes1();
    int lat = 0;
    r1_a = 8'h80; r1_b = 8'h80; r1_cin = 1'b1; r1_valid = 1'b1;
    tick();
    r1_valid = 1'b0;
    while (!r1_rvalid && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL n1_latency: %0d cycles required 1", lat);
    end
    checks++;
    if (r1_sum !== 8'h01 || r1_cout !== 1'b1) begin
      errors++; $display("FAIL n1_result: sum=%h cout=%b required 01 1", r1_sum, r1_cout);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_reset_mid_run();
    test_sub();
    test_nbytes1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
